// File: rtl/alarm_controller.sv
// Wristwatch alarm sequencer: detects the alarm minute and walks the
// armed -> ringing -> snooze machine with auto-off and a 1 s beep pattern.
module alarm_controller #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [3:0] cur0,
  input  logic [3:0] cur1,
  input  logic [3:0] cur2,
  input  logic [3:0] cur3,
  input  logic [3:0] alm0,
  input  logic [3:0] alm1,
  input  logic [3:0] alm2,
  input  logic [3:0] alm3,
  input  logic       alarm_en,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic [1:0] state,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_RINGING = 2'd2;
  localparam logic [1:0] S_SNOOZE  = 2'd3;

  localparam logic [7:0]  RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [12:0] SNZ_LOAD  = 13'(SNOOZE_MIN * 60);

  logic [1:0]  state_q, state_d;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [12:0] snz_cnt_q, snz_cnt_d;
  logic        beep_q, beep_d;
  logic        match_q, stop_q, snz_q;
  logic        ringing_q, snoozing_q, buzzer_q;

  logic match, trigger, stop_p, snz_p;

  assign match   = (cur0 == alm0) && (cur1 == alm1) && (cur2 == alm2) && (cur3 == alm3);
  assign trigger = match & ~match_q;
  assign stop_p  = btn_stop & ~stop_q;
  assign snz_p   = btn_snooze & ~snz_q;

  // Priority: disable > stop > timeout/expiry > snooze.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    beep_d     = beep_q;
    if (!alarm_en) begin
      state_d    = S_IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      beep_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (trigger) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end
        end
        S_RINGING: begin
          if (stop_p) begin
            state_d = S_ARMED;
          end else if (tick_1hz && ring_cnt_q == RING_LAST) begin
            state_d = S_ARMED;
          end else if (snz_p) begin
            state_d   = S_SNOOZE;
            snz_cnt_d = SNZ_LOAD;
          end else if (tick_1hz) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            beep_d     = ~beep_q;
          end
        end
        S_SNOOZE: begin
          if (stop_p) begin
            state_d = S_ARMED;
          end else if (tick_1hz && snz_cnt_q == 13'd1) begin
            state_d    = S_RINGING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end else if (tick_1hz) begin
            snz_cnt_d = snz_cnt_q - 13'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output flags are decoded from the next state so they stay aligned with state_q.
  always_ff @(posedge uclock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      beep_q     <= 1'b0;
      match_q    <= 1'b0;
      stop_q     <= 1'b0;
      snz_q      <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_q     <= beep_d;
      match_q    <= match;
      stop_q     <= btn_stop;
      snz_q      <= btn_snooze;
      ringing_q  <= (state_d == S_RINGING);
      snoozing_q <= (state_d == S_SNOOZE);
      buzzer_q   <= (state_d == S_RINGING) & beep_d;
    end
  end

  assign state    = state_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;
  assign buzzer   = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios plus random traffic, all
// checked every cycle against a seconds-counting reference model.
module tb_alarm_controller;

  localparam int SNZ_MIN = 1;
  localparam int RTO     = 4;
  localparam int SNZ_S   = SNZ_MIN * 60;

  logic       uclock = 1'b0;
  logic       reset, tick_1hz, alarm_en, btn_stop, btn_snooze;
  logic [3:0] cur0, cur1, cur2, cur3, alm0, alm1, alm2, alm3;
  logic [1:0] state;
  logic       ringing, snoozing, buzzer;

  always #5 uclock = ~uclock;

  alarm_controller #(.SNOOZE_MIN(SNZ_MIN), .RING_TIMEOUT_S(RTO)) dut (
    .uclock(uclock), .reset(reset), .tick_1hz(tick_1hz),
    .cur0(cur0), .cur1(cur1), .cur2(cur2), .cur3(cur3),
    .alm0(alm0), .alm1(alm1), .alm2(alm2), .alm3(alm3),
    .alarm_en(alarm_en), .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .state(state), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode plus elapsed seconds in ringing / snooze.
  int m_mode = 0;      // 0 idle, 1 armed, 2 ringing, 3 snooze
  int m_ring_s = 0;    // seconds rung since the latest ring start
  int m_snz_s = 0;     // seconds elapsed in the current snooze
  bit m_prev_match = 0, m_prev_stop = 0, m_prev_snz = 0;

  function automatic bit time_match();
    return {cur3, cur2, cur1, cur0} == {alm3, alm2, alm1, alm0};
  endfunction

  task automatic model_update();
    bit mt, trig, sp, zp;
    mt   = time_match();
    trig = mt && !m_prev_match;
    sp   = btn_stop && !m_prev_stop;
    zp   = btn_snooze && !m_prev_snz;
    if (reset) begin
      m_mode = 0; m_ring_s = 0; m_snz_s = 0;
      m_prev_match = 0; m_prev_stop = 0; m_prev_snz = 0;
    end else begin
      if (!alarm_en) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (trig) begin m_mode = 2; m_ring_s = 0; end
      end else if (m_mode == 2) begin
        if (sp) m_mode = 1;
        else if (tick_1hz && m_ring_s + 1 >= RTO) m_mode = 1;
        else if (zp) begin m_mode = 3; m_snz_s = 0; end
        else if (tick_1hz) m_ring_s++;
      end else begin
        if (sp) m_mode = 1;
        else if (tick_1hz && m_snz_s + 1 == SNZ_S) begin m_mode = 2; m_ring_s = 0; end
        else if (tick_1hz) m_snz_s++;
      end
      m_prev_match = mt; m_prev_stop = btn_stop; m_prev_snz = btn_snooze;
    end
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1 time unit later.
  task automatic step();
    bit exp_buz;
    @(posedge uclock);
    model_update();
    #1;
    exp_buz = (m_mode == 2) && (m_ring_s % 2 == 0);
    chk("state", 16'(state), 16'(m_mode));
    chk("ringing", 16'(ringing), 16'(m_mode == 2));
    chk("snoozing", 16'(snoozing), 16'(m_mode == 3));
    chk("buzzer", 16'(buzzer), 16'(exp_buz));
  endtask

  task automatic set_time(input int hh, input int mm);
    cur0 = 4'(mm % 10); cur1 = 4'(mm / 10);
    cur2 = 4'(hh % 10); cur3 = 4'(hh / 10);
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
  endtask

  task automatic start_ring();
    set_time(7, 31); step();
    set_time(7, 30); step();
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0;
    btn_stop = 1'b0; btn_snooze = 1'b0;
    alm0 = 4'd0; alm1 = 4'd3; alm2 = 4'd7; alm3 = 4'd0;
    set_time(7, 29);
    step(); step();
    chk("rst_state", 16'(state), 16'd0);
    reset = 1'b0; alarm_en = 1'b1;
    step(); step();
    chk("armed", 16'(state), 16'd1);

    // Ring and auto-off, no re-trigger for the rest of 07:30
    set_time(7, 30); step();
    chk("t1_ring", 16'(state), 16'd2);
    chk("t1_buz", 16'(buzzer), 16'd1);
    for (int i = 0; i < RTO; i++) tick_once();
    chk("t1_autooff", 16'(state), 16'd1);
    for (int i = 0; i < 20; i++) step();

    // Stop held for 10 cycles
    start_ring();
    btn_stop = 1'b1; step();
    chk("t2_stop", 16'(state), 16'd1);
    for (int i = 0; i < 9; i++) step();
    btn_stop = 1'b0; step();

    // Snooze cycle, with snooze presses ignored
    start_ring();
    btn_snooze = 1'b1; step();
    chk("t3_snz", 16'(state), 16'd3);
    btn_snooze = 1'b0;
    for (int i = 0; i < SNZ_S; i++) begin
      btn_snooze = (i % 7 == 3);
      tick_once();
    end
    btn_snooze = 1'b0;
    chk("t3_rering", 16'(state), 16'd2);
    chk("t3_buz", 16'(buzzer), 16'd1);

    // Stop and snooze together, then timeout tick with snooze
    btn_stop = 1'b1; btn_snooze = 1'b1; step();
    chk("t5_both", 16'(state), 16'd1);
    btn_stop = 1'b0; btn_snooze = 1'b0;
    start_ring();
    for (int i = 0; i < RTO - 1; i++) tick_once();
    tick_1hz = 1'b1; btn_snooze = 1'b1; step();
    chk("t5_tmo_snz", 16'(state), 16'd1);
    tick_1hz = 1'b0; btn_snooze = 1'b0; step();

    // Disable in ringing, re-enable during the matching minute
    start_ring();
    alarm_en = 1'b0; step();
    chk("t4_dis", 16'(state), 16'd0);
    alarm_en = 1'b1; step(); step(); step();
    chk("t4_reen", 16'(state), 16'd1);

    // Reset in snooze with enable held
    start_ring();
    btn_snooze = 1'b1; step(); btn_snooze = 1'b0; step();
    reset = 1'b1; step();
    chk("t6_rst", 16'(state), 16'd0);
    reset = 1'b0; step();
    chk("t6_rearm", 16'(state), 16'd1);

    // Random traffic
    for (int c = 0; c < 15000; c++) begin
      reset = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 399) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(0, 149) == 0) btn_stop = ~btn_stop;
      if ($urandom_range(0, 99) == 0) btn_snooze = ~btn_snooze;
      tick_1hz = !tick_1hz && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) set_time(7, 29 + $urandom_range(0, 2));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
